uart_rx_fifo: RTL

Receive-side byte buffer between the UART receiver and the core-facing register interface. Each byte the receiver delivers is captured into a circular FIFO, and the CPU drains it through a single-cycle read handshake. Overflow and framing errors are recorded as sticky flags, and an interrupt is raised on a programmable fill level. The FIFO hides interrupt latency for the 9.216 Mbaud link used by the snake game and similar console programs.

---
 rtl/uart_rx_fifo_if.sv | 31 +++
 rtl/uart_rx_fifo.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Handshake/status bundle between the UART receiver, the CPU register block and uart_rx_fifo.
interface uart_rx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_frame_error;
  logic                  rd_en;
  logic [7:0]            rd_data;
  logic                  rd_valid;
  logic                  flush;
  logic                  clear_flags;
  logic [DEPTH_LOG2:0]   threshold;
  logic [DEPTH_LOG2:0]   level;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  frame_error;
  logic                  timeout;
  logic                  irq;

  modport master (
    output rx_valid, rx_data, rx_frame_error, rd_en, flush, clear_flags, threshold,
    input  rd_data, rd_valid, level, empty, full, overflow, frame_error, timeout, irq
  );

  modport slave (
    input  rx_valid, rx_data, rx_frame_error, rd_en, flush, clear_flags, threshold,
    output rd_data, rd_valid, level, empty, full, overflow, frame_error, timeout, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO with sticky error flags and fill-level interrupt.
// Optional idle-data timeout flag is built when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic            clk,
  input logic            rst,
  uart_rx_fifo_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          empty_q;
  logic          full_q;
  logic [7:0]    rd_data_q;
  logic          rd_valid_q;
  logic          overflow_q;
  logic          frame_error_q;
  logic          timeout_q;

  logic wr_req;
  logic fe_evt;
  logic is_empty;
  logic is_full;
  logic acc_rd;
  logic acc_wr;
  logic ovf_evt;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a concurrent write.
  always_comb begin
    wr_req   = bus.rx_valid & ~bus.rx_frame_error;
    fe_evt   = ~bus.flush & bus.rx_valid & bus.rx_frame_error;
    is_empty = (count == '0);
    is_full  = (count == CW'(DEPTH));
    acc_rd   = ~bus.flush & bus.rd_en & ~is_empty;
    acc_wr   = ~bus.flush & wr_req & (~is_full | acc_rd);
    ovf_evt  = ~bus.flush & wr_req & is_full & ~acc_rd;
  end

  always_comb begin
    count_nxt = count;
    if (bus.flush) begin
      count_nxt = '0;
    end else if (acc_wr && !acc_rd) begin
      count_nxt = count + CW'(1);
    end else if (acc_rd && !acc_wr) begin
      count_nxt = count - CW'(1);
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      mem[wptr] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      rd_data_q     <= 8'h00;
      rd_valid_q    <= 1'b0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      count      <= count_nxt;
      empty_q    <= (count_nxt == '0);
      full_q     <= (count_nxt == CW'(DEPTH));
      rd_valid_q <= acc_rd;
      if (bus.flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (acc_wr) begin
          wptr <= wptr + PW'(1);
        end
        if (acc_rd) begin
          rptr      <= rptr + PW'(1);
          rd_data_q <= mem[rptr];
        end
      end
      // A new error event in the same cycle beats clear_flags.
      if (ovf_evt) begin
        overflow_q <= 1'b1;
      end else if (bus.clear_flags) begin
        overflow_q <= 1'b0;
      end
      if (fe_evt) begin
        frame_error_q <= 1'b1;
      end else if (bus.clear_flags) begin
        frame_error_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] idle_cnt;
  logic        idle_inc;

  assign idle_inc = (count != '0) && (idle_cnt != IDLE_LIMIT);

  // Saturating idle counter so the flag fires once per idle period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      if (bus.flush || acc_wr || acc_rd) begin
        idle_cnt <= 16'd0;
      end else if (idle_inc) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
      if (bus.flush || acc_rd) begin
        timeout_q <= 1'b0;
      end else if (!acc_wr && idle_inc && (idle_cnt + 16'd1 == IDLE_LIMIT)) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
  assign timeout_q          = 1'b0;
`endif

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.level       = count;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.overflow    = overflow_q;
  assign bus.frame_error = frame_error_q;
  assign bus.timeout     = timeout_q;
  assign bus.irq         = ((bus.threshold != '0) && (count >= bus.threshold)) | timeout_q;
endmodule
